// File: rtl/valu_pkg.sv
// Shared encodings for the vector ALU decode and sequencing logic.
package valu_pkg;

  localparam logic [6:0] OPC_OPV   = 7'b1010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000111;
  localparam logic [6:0] OPC_STORE = 7'b0100111;

  localparam logic [5:0] F6_ADD    = 6'b000000;
  localparam logic [5:0] F6_SUB    = 6'b000010;
  localparam logic [5:0] F6_RSUB   = 6'b000011;
  localparam logic [5:0] F6_MINU   = 6'b000100;
  localparam logic [5:0] F6_MIN    = 6'b000101;
  localparam logic [5:0] F6_MAXU   = 6'b000110;
  localparam logic [5:0] F6_MAX    = 6'b000111;
  localparam logic [5:0] F6_AND    = 6'b001001;
  localparam logic [5:0] F6_OR     = 6'b001010;
  localparam logic [5:0] F6_XOR    = 6'b001011;
  localparam logic [5:0] F6_MERGE  = 6'b010111;
  localparam logic [5:0] F6_MSEQ   = 6'b011000;
  localparam logic [5:0] F6_MSNE   = 6'b011001;
  localparam logic [5:0] F6_MSLTU  = 6'b011010;
  localparam logic [5:0] F6_MSLT   = 6'b011011;
  localparam logic [5:0] F6_MSLEU  = 6'b011100;
  localparam logic [5:0] F6_MSLE   = 6'b011101;
  localparam logic [5:0] F6_MSGTU  = 6'b011110;
  localparam logic [5:0] F6_MSGT   = 6'b011111;
  localparam logic [5:0] F6_SLL    = 6'b100101;
  localparam logic [5:0] F6_SRL    = 6'b101000;
  localparam logic [5:0] F6_SRA    = 6'b101001;
  // Highest funct6 accepted on the load/store opcodes.
  localparam logic [5:0] F6_MEM_MAX = 6'b000010;

  typedef enum logic [4:0] {
    SEL_ADD   = 5'd0,
    SEL_SUB   = 5'd1,
    SEL_RSUB  = 5'd2,
    SEL_AND   = 5'd3,
    SEL_OR    = 5'd4,
    SEL_XOR   = 5'd5,
    SEL_SLL   = 5'd6,
    SEL_SRL   = 5'd7,
    SEL_SRA   = 5'd8,
    SEL_MSEQ  = 5'd9,
    SEL_MSNE  = 5'd10,
    SEL_MSLTU = 5'd11,
    SEL_MSLT  = 5'd12,
    SEL_MSLEU = 5'd13,
    SEL_MSLE  = 5'd14,
    SEL_MSGTU = 5'd15,
    SEL_MSGT  = 5'd16,
    SEL_MINU  = 5'd17,
    SEL_MIN   = 5'd18,
    SEL_MAXU  = 5'd19,
    SEL_MAX   = 5'd20,
    SEL_MERGE = 5'd21
  } valu_sel_e;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  function automatic logic sel_is_mask(valu_sel_e sel);
    return (sel >= SEL_MSEQ) && (sel <= SEL_MSGT);
  endfunction

endpackage

// File: rtl/valu_decode.sv
// Combinational opcode/funct6 decoder; unsupported encodings raise illegal and select add.
module valu_decode
  import valu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [5:0] funct,
  output valu_sel_e  sel,
  output logic       is_mask,
  output logic       is_mem,
  output logic       illegal
);

  always_comb begin
    sel     = SEL_ADD;
    is_mem  = 1'b0;
    illegal = 1'b0;
    if (opcode == OPC_OPV) begin
      case (funct)
        F6_ADD:   sel = SEL_ADD;
        F6_SUB:   sel = SEL_SUB;
        F6_RSUB:  sel = SEL_RSUB;
        F6_AND:   sel = SEL_AND;
        F6_OR:    sel = SEL_OR;
        F6_XOR:   sel = SEL_XOR;
        F6_SLL:   sel = SEL_SLL;
        F6_SRL:   sel = SEL_SRL;
        F6_SRA:   sel = SEL_SRA;
        F6_MSEQ:  sel = SEL_MSEQ;
        F6_MSNE:  sel = SEL_MSNE;
        F6_MSLTU: sel = SEL_MSLTU;
        F6_MSLT:  sel = SEL_MSLT;
        F6_MSLEU: sel = SEL_MSLEU;
        F6_MSLE:  sel = SEL_MSLE;
        F6_MSGTU: sel = SEL_MSGTU;
        F6_MSGT:  sel = SEL_MSGT;
        F6_MINU:  sel = SEL_MINU;
        F6_MIN:   sel = SEL_MIN;
        F6_MAXU:  sel = SEL_MAXU;
        F6_MAX:   sel = SEL_MAX;
        F6_MERGE: sel = SEL_MERGE;
        default:  illegal = 1'b1;
      endcase
    end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
      if (funct <= F6_MEM_MAX) begin
        is_mem = 1'b1;
      end else begin
        illegal = 1'b1;
      end
    end else begin
      illegal = 1'b1;
    end
    is_mask = sel_is_mask(sel);
  end

endmodule

// File: rtl/valu_sequencer.sv
// Accepts one vector instruction, decodes it and streams LANES-wide groups with tail enables.
module valu_sequencer
  import valu_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned VLMAX = 32,
  parameter int unsigned VL_W  = $clog2(VLMAX + 1),
  parameter int unsigned GRP_W = (VLMAX / LANES > 1) ? $clog2(VLMAX / LANES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [VL_W-1:0]  vl,
  output logic             grp_valid,
  input  logic             grp_ready,
  output logic [4:0]       valuSel,
  output logic [GRP_W-1:0] grp_idx,
  output logic [LANES-1:0] lane_en,
  output logic             grp_last,
  output logic             is_mask,
  output logic             is_mem,
  output logic             done,
  output logic             illegal
);

  valu_sel_e dec_sel;
  logic      dec_mask, dec_mem, dec_illegal;

  valu_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .sel     (dec_sel),
    .is_mask (dec_mask),
    .is_mem  (dec_mem),
    .illegal (dec_illegal)
  );

  state_e           state_q, state_d;
  valu_sel_e        sel_q, sel_d;
  logic             mask_q, mask_d, mem_q, mem_d;
  logic             done_q, done_d, illegal_q, illegal_d;
  logic [VL_W-1:0]  veff, veff_q, veff_d;
  logic [GRP_W-1:0] idx_q, idx_d, last_q, last_d;
  logic [31:0]      base;
  logic             run;

  assign veff = (vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    mem_d     = mem_q;
    veff_d    = veff_q;
    idx_d     = idx_q;
    last_d    = last_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sel_d  = dec_sel;
          mask_d = dec_mask;
          mem_d  = dec_mem;
          veff_d = veff;
          idx_d  = '0;
          // Index of the final group, ceil(veff/LANES)-1; unused when veff is zero.
          last_d = GRP_W'((32'(veff) - 32'd1) / LANES);
          if (dec_illegal) begin
            illegal_d = 1'b1;
          end else if (veff == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (grp_ready) begin
          if (idx_q == last_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sel_q     <= SEL_ADD;
      mask_q    <= 1'b0;
      mem_q     <= 1'b0;
      veff_q    <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      mem_q     <= mem_d;
      veff_q    <= veff_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Group outputs derive only from registered state, so they hold across a stall.
  assign run  = (state_q == StRun);
  assign base = 32'(idx_q) * LANES;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_en[i] = run && ((base + 32'(i)) < 32'(veff_q));
  end

  assign in_ready  = (state_q == StIdle);
  assign grp_valid = run;
  assign grp_last  = run && (idx_q == last_q);
  assign grp_idx   = idx_q;
  assign valuSel   = sel_q;
  assign is_mask   = mask_q;
  assign is_mem    = mem_q;
  assign done      = done_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_valu_sequencer.sv
// Self-checking bench: directed table, corner sequences and randomized traffic vs a reference model.
module tb_valu_sequencer;

  localparam int unsigned LANES = 4;
  localparam int unsigned VLMAX = 32;
  localparam int unsigned VL_W  = $clog2(VLMAX + 1);
  localparam int unsigned GRP_W = $clog2(VLMAX / LANES);

  localparam logic [6:0] OPV   = 7'b1010111;
  localparam logic [6:0] LOAD  = 7'b0000111;
  localparam logic [6:0] STORE = 7'b0100111;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             grp_ready = 1'b0;
  logic [6:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic [VL_W-1:0]  vl = '0;
  logic             in_ready, grp_valid, grp_last, is_mask, is_mem, done, illegal;
  logic [4:0]       valuSel;
  logic [GRP_W-1:0] grp_idx;
  logic [LANES-1:0] lane_en;

  valu_sequencer #(.LANES(LANES), .VLMAX(VLMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .vl        (vl),
    .grp_valid (grp_valid),
    .grp_ready (grp_ready),
    .valuSel   (valuSel),
    .grp_idx   (grp_idx),
    .lane_en   (lane_en),
    .grp_last  (grp_last),
    .is_mask   (is_mask),
    .is_mem    (is_mem),
    .done      (done),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit ready_q[$];

  typedef struct {
    logic [6:0] op;
    logic [5:0] f;
    int         vlen;
    int         sel;
    bit         mask;
    bit         mem;
    bit         ill;
    int         ngrp;
    int         lat;
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode written straight from the encoding rules.
  function automatic void ref_decode(input logic [6:0] op, input logic [5:0] f,
                                     output int sel, output bit mask, output bit mem,
                                     output bit ill);
    int fi;
    fi   = int'(f);
    sel  = 0;
    mem  = 1'b0;
    ill  = 1'b0;
    if (op == OPV) begin
      if (fi == 0) sel = 0;
      else if (fi == 2) sel = 1;
      else if (fi == 3) sel = 2;
      else if (fi == 9) sel = 3;
      else if (fi == 10) sel = 4;
      else if (fi == 11) sel = 5;
      else if (fi == 37) sel = 6;
      else if (fi == 40) sel = 7;
      else if (fi == 41) sel = 8;
      else if (fi >= 24 && fi <= 31) sel = 9 + (fi - 24);
      else if (fi >= 4 && fi <= 7) sel = 17 + (fi - 4);
      else if (fi == 23) sel = 21;
      else ill = 1'b1;
    end else if ((op == LOAD || op == STORE) && fi <= 2) begin
      mem = 1'b1;
    end else begin
      ill = 1'b1;
    end
    mask = (sel >= 9) && (sel <= 16);
  endfunction

  function automatic bit pick_ready(input int pct);
    if (ready_q.size() > 0) return ready_q.pop_front();
    return $urandom_range(99) < pct;
  endfunction

  task automatic check_reset_state();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_grp_valid", 32'(grp_valid), 0);
    check("rst_valuSel", 32'(valuSel), 0);
    check("rst_grp_idx", 32'(grp_idx), 0);
    check("rst_lane_en", 32'(lane_en), 0);
    check("rst_grp_last", 32'(grp_last), 0);
    check("rst_is_mask", 32'(is_mask), 0);
    check("rst_is_mem", 32'(is_mem), 0);
    check("rst_done", 32'(done), 0);
    check("rst_illegal", 32'(illegal), 0);
  endtask

  // Issue one instruction in the current (idle) cycle and follow it to done/illegal.
  task automatic run_instr(input logic [6:0] op, input logic [5:0] f, input int vlen,
                           input int pct, output int ng_seen, output int lat);
    int sel, veff, ng, g, cyc, m;
    bit mask, mem, ill;
    ref_decode(op, f, sel, mask, mem, ill);
    veff = (vlen > int'(VLMAX)) ? int'(VLMAX) : vlen;
    ng   = (veff + int'(LANES) - 1) / int'(LANES);
    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    opcode   = op;
    funct    = f;
    vl       = VL_W'(vlen);
    step();
    in_valid = 1'b0;
    lat      = 1;
    g        = 0;
    ng_seen  = 0;
    if (ill) begin
      check("illegal_pulse", 32'(illegal), 1);
      check("illegal_no_done", 32'(done), 0);
      check("illegal_no_grp", 32'(grp_valid), 0);
      check("illegal_in_ready", 32'(in_ready), 1);
      return;
    end
    check("valuSel", 32'(valuSel), sel);
    check("is_mask", 32'(is_mask), 32'(mask));
    check("is_mem", 32'(is_mem), 32'(mem));
    if (ng == 0) begin
      check("vl0_done", 32'(done), 1);
      check("vl0_illegal", 32'(illegal), 0);
      check("vl0_no_grp", 32'(grp_valid), 0);
      check("vl0_in_ready", 32'(in_ready), 1);
      return;
    end
    cyc = 0;
    while (g < ng && cyc < 400) begin
      m = 0;
      for (int i = 0; i < int'(LANES); i++) begin
        if (g * int'(LANES) + i < veff) m = m | (1 << i);
      end
      check("grp_valid", 32'(grp_valid), 1);
      check("run_in_ready", 32'(in_ready), 0);
      check("run_done", 32'(done), 0);
      check("run_illegal", 32'(illegal), 0);
      check("grp_idx", 32'(grp_idx), g);
      check("lane_en", 32'(lane_en), m);
      check("grp_last", 32'(grp_last), 32'(g == ng - 1));
      check("run_valuSel", 32'(valuSel), sel);
      check("run_is_mask", 32'(is_mask), 32'(mask));
      check("run_is_mem", 32'(is_mem), 32'(mem));
      grp_ready = pick_ready(pct);
      // Offer junk instructions while busy; they must be ignored.
      in_valid  = 1'($urandom_range(1));
      opcode    = 7'($urandom);
      funct     = 6'($urandom);
      vl        = VL_W'($urandom);
      step();
      lat++;
      cyc++;
      if (grp_ready) g++;
    end
    in_valid  = 1'b0;
    grp_ready = 1'b0;
    ng_seen   = g;
    check("grp_count", g, ng);
    check("done_pulse", 32'(done), 1);
    check("done_in_ready", 32'(in_ready), 1);
    check("done_no_grp", 32'(grp_valid), 0);
    check("done_no_illegal", 32'(illegal), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    int ng, lat, r, vlr, pct, gap;
    logic [6:0] op;
    logic [5:0] f;

    tbl[0]  = '{OPV,   6'b000010, 10, 1,  0, 0, 0, 3, 4};
    tbl[1]  = '{OPV,   6'b011011, 8,  12, 1, 0, 0, 2, 3};
    tbl[2]  = '{OPV,   6'b111111, 5,  0,  0, 0, 1, 0, 1};
    tbl[3]  = '{LOAD,  6'b000000, 0,  0,  0, 1, 0, 0, 1};
    tbl[4]  = '{OPV,   6'b000000, 40, 0,  0, 0, 0, 8, 9};
    tbl[5]  = '{STORE, 6'b000010, 1,  0,  0, 1, 0, 1, 2};
    tbl[6]  = '{OPV,   6'b000111, 32, 20, 0, 0, 0, 8, 9};
    tbl[7]  = '{OPV,   6'b010111, 3,  21, 0, 0, 0, 1, 2};
    tbl[8]  = '{LOAD,  6'b000011, 7,  0,  0, 0, 1, 0, 1};
    tbl[9]  = '{7'b0110011, 6'b000000, 7, 0, 0, 0, 1, 0, 1};
    tbl[10] = '{OPV,   6'b101001, 31, 8,  0, 0, 0, 8, 9};
    tbl[11] = '{OPV,   6'b011111, 5,  16, 1, 0, 0, 2, 3};

    rst = 1'b1;
    step();
    step();
    check_reset_state();
    rst = 1'b0;

    // Directed table, issued back to back from each done/illegal cycle.
    for (int k = 0; k < 12; k++) begin
      run_instr(tbl[k].op, tbl[k].f, tbl[k].vlen, 100, ng, lat);
      check("tbl_groups", ng, tbl[k].ngrp);
      check("tbl_latency", lat, tbl[k].lat);
      if (!tbl[k].ill) begin
        check("tbl_valuSel", 32'(valuSel), tbl[k].sel);
        check("tbl_is_mask", 32'(is_mask), 32'(tbl[k].mask));
        check("tbl_is_mem", 32'(is_mem), 32'(tbl[k].mem));
      end
    end

    // vmslt with a stalled second group.
    step();
    ready_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_instr(OPV, 6'b011011, 8, 100, ng, lat);
    check("stall_groups", ng, 2);
    check("stall_latency", lat, 5);
    check("stall_valuSel", 32'(valuSel), 12);
    check("stall_is_mask", 32'(is_mask), 1);

    // Reset during group 1 abandons the instruction silently.
    step();
    in_valid = 1'b1;
    opcode   = OPV;
    funct    = 6'b000000;
    vl       = VL_W'(16);
    step();
    in_valid  = 1'b0;
    grp_ready = 1'b1;
    step();
    check("pre_rst_grp_idx", 32'(grp_idx), 1);
    grp_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state();
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_done", 32'(done), 0);
      check("post_rst_grp_valid", 32'(grp_valid), 0);
    end
    run_instr(OPV, 6'b000000, 4, 100, ng, lat);
    check("post_rst_groups", ng, 1);
    check("post_rst_latency", lat, 2);

    // Randomized traffic with stalls and idle gaps.
    for (int k = 0; k < 200; k++) begin
      r  = int'($urandom_range(9));
      op = (r < 5) ? OPV : (r < 7) ? LOAD : (r < 9) ? STORE : 7'($urandom);
      f  = (op != OPV && $urandom_range(1) == 1) ? 6'($urandom_range(3)) : 6'($urandom);
      vlr = int'($urandom_range(45));
      if ($urandom_range(7) == 0) vlr = 0;
      pct = int'($urandom_range(100, 30));
      run_instr(op, f, vlr, pct, ng, lat);
      gap = int'($urandom_range(2));
      for (int j = 0; j < gap; j++) begin
        step();
        check("gap_done", 32'(done), 0);
        check("gap_illegal", 32'(illegal), 0);
        check("gap_grp_valid", 32'(grp_valid), 0);
        check("gap_in_ready", 32'(in_ready), 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/valu_sequencer.md
# valu_sequencer

Parametrised successor to the vector ALU control decoder. It accepts one vector instruction (opcode, funct6, vl) per handshake and decodes it to a 5-bit ALU select. It then issues the operation as a stream of lane groups of LANES elements each, with per-lane tail enables, to the vector ALU datapath. It also flags encodings the decoder does not support, which the combinational decoder silently mapped to add.

## Interface
Parameters:
- LANES, 4, elements processed per group; power of two, ≥1
- VLMAX, 32, maximum vector length in elements; multiple of LANES
- VL_W, $clog2(VLMAX+1), width of vl
- GRP_W, $clog2(VLMAX/LANES), width of group index (min 1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept (high only in IDLE)
- opcode  in  7  major opcode
- funct  in  6  funct6 field
- vl  in  VL_W  active vector length
- grp_valid  out  1  a lane group is presented
- grp_ready  in  1  datapath consumes the group
- valuSel  out  5  ALU select for current instruction
- grp_idx  out  GRP_W  index of current group
- lane_en  out  LANES  per-lane enable (tail mask)
- grp_last  out  1  current group is the final one
- is_mask  out  1  instruction writes a mask (compare ops)
- is_mem  out  1  instruction is a load/store
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse, unsupported encoding rejected

## Operation
- Decode for opcode 1010111, by funct6 → valuSel:
  - 000000→0, 000010→1, 000011→2
  - 001001→3, 001010→4, 001011→5
  - 100101→6, 101000→7, 101001→8
  - 011000..011111→9..16
  - 000100..000111→17..20
  - 010111→21
- Decode for opcode 0000111 (load) or 0100111 (store), funct6 ∈ {000000, 000001, 000010} → valuSel 0, is_mem=1.
- Every other {opcode,funct} is illegal.
- is_mask=1 iff valuSel in 9..16.
- States: IDLE, RUN.
- IDLE:
  - in_ready=1.
  - On in_valid: latch the decode and veff = min(vl, VLMAX).
  - If illegal: pulse illegal next cycle, stay IDLE, no groups.
  - If veff==0: pulse done next cycle, stay IDLE, no groups.
  - Otherwise go to RUN with grp_idx=0.
- RUN:
  - grp_valid=1.
  - lane_en[i] = (grp_idx*LANES + i < veff).
  - grp_last = (grp_idx == ceil(veff/LANES)-1).
  - On grp_valid&grp_ready with !grp_last: grp_idx+1.
  - On grp_valid&grp_ready with grp_last: pulse done next cycle, return to IDLE.
- valuSel, is_mask and is_mem are held from accept until the next accept.
- done and illegal are never high together.

## Timing
- Reset values: in_ready=1 (IDLE); grp_valid=0, valuSel=0, grp_idx=0, lane_en=0, grp_last=0, is_mask=0, is_mem=0, done=0, illegal=0.
- Accept at edge N → grp_valid high in cycle N+1.
- Throughput is one group per cycle while grp_ready=1.
- G groups with no stall: done in cycle N+G+1, in_ready high in the same cycle.
- Back-to-back: a new instruction can be accepted in the done cycle.
- The group outputs are registered and remain stable while grp_valid & !grp_ready (no change without handshake).
- in_ready is low throughout RUN; in_valid is ignored there.
- rst mid-RUN: the next cycle shows reset values. The instruction is abandoned with no done pulse.
- vl > VLMAX is clamped; it is not an error.

## Structure
- Package valu_pkg:
  - OPC_OPV, OPC_LOAD, OPC_STORE opcode constants
  - funct6 constants
  - valuSel enum (SEL_ADD..SEL_MERGE, 5 bits)
  - state enum
- Sub-module valu_decode: purely combinational, opcode/funct → {valuSel, is_mask, is_mem, illegal}. It is reused by the scalar-vector issue path.
- valu_sequencer holds the FSM, group counter and tail-mask generation.

## Test plan
- LANES=4, VLMAX=32. vsub (1010111/000010), vl=10, grp_ready=1:
  - valuSel=1, three groups, idx 0,1,2.
  - lane_en 1111, 1111, 0011; grp_last only on idx 2.
  - done 4 cycles after accept.
- vmslt (funct 011011), vl=8, grp_ready toggling 1,0,0,1:
  - valuSel=12, is_mask=1.
  - Group 1 outputs held unchanged during the stall.
  - done after the second handshake.
- opcode 1010111, funct 111111: illegal pulse 1 cycle after accept, no grp_valid, in_ready stays 1.
- vle (0000111/000000), vl=0: is_mem=1, valuSel=0, done pulse next cycle, no groups.
- vl=40 (exceeds VLMAX): exactly 8 groups, all lane_en=1111.
- rst asserted during group 1 of a vl=16 op: all outputs at reset values the next cycle, no done. A following vadd with vl=4 runs normally (1 group, lane_en=1111).
